// File: rtl/cond_branch_decoder_pkg.sv
// Shared types for the conditional-branch decoder: branch codes, FSM states
// and the mapping from the producer's {out1,out0} pair to a branch code.
package cond_branch_pkg;

   typedef enum logic [1:0] {
      BR_IF    = 2'd0,
      BR_ELSIF = 2'd1,
      BR_ELSE  = 2'd2,
      BR_INIT  = 2'd3
   } branch_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      EMIT   = 2'd2,
      DRAIN  = 2'd3
   } state_e;

   function automatic branch_e decode_pair(input logic [1:0] pair);
      branch_e br;
      case (pair)
         2'b01:   br = BR_IF;
         2'b10:   br = BR_ELSIF;
         2'b00:   br = BR_ELSE;
         default: br = BR_INIT;
      endcase
      return br;
   endfunction

endpackage

// File: rtl/cond_branch_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cond_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/cond_branch_decoder.sv
// Debounces the {in1,in0} pair, decodes the branch that produced it and hands
// the code to the monitor over valid/ready, keeping per-branch hit counts.
module cond_branch_decoder
   import cond_branch_pkg::*;
#(
   parameter int STABLE_CYCLES = 3,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0,
   input  logic             in1,
   input  logic             in_valid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       branch_id,
   output logic             busy,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_if,
   output logic [CNT_W-1:0] cnt_elsif,
   output logic [CNT_W-1:0] cnt_else,
   output logic [CNT_W-1:0] cnt_init,
   output logic [CNT_W-1:0] cnt_glitch
);

   localparam int             SC_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_TARGET = SC_W'(STABLE_CYCLES);

   state_e          state_q;
   logic [1:0]      sample_q;
   logic [SC_W-1:0] stable_cnt_q;
   logic            out_valid_q;
   branch_e         branch_id_q;
   logic            busy_q;

   logic [1:0]       pair;
   logic             handshake;
   logic             glitch;
   logic [4:0]       inc_vec;
   logic [CNT_W-1:0] cnt_arr [5];

   assign pair      = {in1, in0};
   assign handshake = (state_q == EMIT) && out_valid_q && out_ready;
   assign glitch    = (state_q == SETTLE) && in_valid && (pair != sample_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sample_q     <= '0;
         stable_cnt_q <= '0;
         out_valid_q  <= 1'b0;
         branch_id_q  <= BR_IF;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sample_q     <= pair;
                  stable_cnt_q <= SC_W'(1);
                  busy_q       <= 1'b1;
                  // A single required sample means the first capture is already stable.
                  if (STABLE_CYCLES == 1) begin
                     state_q     <= EMIT;
                     out_valid_q <= 1'b1;
                     branch_id_q <= decode_pair(pair);
                  end else begin
                     state_q <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (!in_valid) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (pair != sample_q) begin
                  sample_q     <= pair;
                  stable_cnt_q <= SC_W'(1);
               end else if ((stable_cnt_q + SC_W'(1)) == SC_TARGET) begin
                  stable_cnt_q <= SC_TARGET;
                  state_q      <= EMIT;
                  out_valid_q  <= 1'b1;
                  branch_id_q  <= decode_pair(sample_q);
               end else begin
                  stable_cnt_q <= stable_cnt_q + SC_W'(1);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (!in_valid) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // Slots 0..3 follow the branch code; slot 4 counts settle-time reloads.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit_inc
         assign inc_vec[gi] = handshake && (branch_id_q == branch_e'(gi));
      end
   endgenerate
   assign inc_vec[4] = glitch;

   generate
      for (gi = 0; gi < 5; gi++) begin : g_cnt
         cond_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc_vec[gi]),
            .clr (clr_cnt),
            .q   (cnt_arr[gi])
         );
      end
   endgenerate

   assign out_valid  = out_valid_q;
   assign branch_id  = branch_id_q;
   assign busy       = busy_q;
   assign cnt_if     = cnt_arr[0];
   assign cnt_elsif  = cnt_arr[1];
   assign cnt_else   = cnt_arr[2];
   assign cnt_init   = cnt_arr[3];
   assign cnt_glitch = cnt_arr[4];

endmodule
